// File: rtl/seq_event_log_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_event_log_if
// Description : Bundles the event-logger signals between the detector/display
//               side (master) and the logger itself (slave).
//               seq_det, max_tick, step : master -> slave
//               hex0..hex3, count, empty, full, overflow : slave -> master
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_event_log_if;
  logic       seq_det;   // one-cycle pulse per detected sequence
  logic       max_tick;  // one-cycle pulse at the end of each LFSR period
  logic       step;      // debounced button level
  logic [3:0] hex0;      // head timestamp bits [3:0]
  logic [3:0] hex1;      // head timestamp bits [7:4]
  logic [3:0] hex2;      // head timestamp bits [11:8]
  logic [3:0] hex3;      // head timestamp bits [15:12]
  logic [4:0] count;     // stored entries
  logic       empty;
  logic       full;
  logic       overflow;  // sticky: a detection was dropped

  modport master (
    output seq_det, max_tick, step,
    input  hex0, hex1, hex2, hex3, count, empty, full, overflow
  );

  modport slave (
    input  seq_det, max_tick, step,
    output hex0, hex1, hex2, hex3, count, empty, full, overflow
  );
endinterface
`default_nettype wire

// File: rtl/seq_event_log.sv
`default_nettype none
// ============================================================================
// Module      : seq_event_log
// Description : Timestamps sequence detections within the current LFSR period
//               and queues them in a small FIFO. The head entry is shown as
//               four hex digits; a rising edge on the step button pops it.
// Ports       : clk   - system clock
//               reset - synchronous, active-low reset
//               bus   - seq_event_log_if.slave (seq_det, max_tick, step in;
//                       hex0..hex3, count, empty, full, overflow out)
// Revision    : 1.0 - initial release
// ============================================================================
module seq_event_log #(
  parameter int DEPTH = 8,
  parameter int TS_W  = 16
) (
  input  wire             clk,
  input  wire             reset,
  seq_event_log_if.slave  bus
);

  localparam int         PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [4:0] C_DEPTH = 5'(DEPTH);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_PRESSED = 1'b1
  } step_state_t;

  logic [TS_W-1:0]  r_ts;
  logic [TS_W-1:0]  r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [4:0]       r_count;
  logic             r_empty;
  logic             r_full;
  logic             r_overflow;
  logic [TS_W-1:0]  r_disp;
  step_state_t      r_state;

  logic w_pop_req;
  logic w_pop;
  logic w_push;

  // The pop request is decoded from the FSM state and the live button level,
  // so the FIFO pops on the very edge that moves the FSM to PRESSED.
  assign w_pop_req = (r_state == S_IDLE) && bus.step;
  assign w_pop     = w_pop_req && (r_count != 5'd0);
  // When full, a same-edge pop frees the slot the push needs.
  assign w_push    = bus.seq_det && ((r_count < C_DEPTH) || w_pop);

  // Step detector: one request per press, none while held.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (bus.step)  r_state <= S_PRESSED;
        S_PRESSED: if (!bus.step) r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Position within the LFSR period; saturates rather than wrapping so a
  // missing max_tick shows up as 0xFFFF instead of a bogus small value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ts <= '0;
    end else if (bus.max_tick) begin
      r_ts <= '0;
    end else if (r_ts != {TS_W{1'b1}}) begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  // Storage needs no reset; count/pointers define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_ts;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= 5'd0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);

      case ({w_push, w_pop})
        2'b10: begin
          r_count <= r_count + 5'd1;
          r_empty <= 1'b0;
          r_full  <= (r_count + 5'd1 == C_DEPTH);
        end
        2'b01: begin
          r_count <= r_count - 5'd1;
          r_empty <= (r_count == 5'd1);
          r_full  <= 1'b0;
        end
        default: ;
      endcase

      if (bus.seq_det && !w_push) r_overflow <= 1'b1;
    end
  end

  // Display follows the head one edge behind the FIFO state.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_disp <= '0;
    end else if (r_count == 5'd0) begin
      r_disp <= '0;
    end else begin
      r_disp <= r_mem[r_rd_ptr];
    end
  end

  assign bus.hex0     = r_disp[3:0];
  assign bus.hex1     = r_disp[7:4];
  assign bus.hex2     = r_disp[11:8];
  assign bus.hex3     = r_disp[15:12];
  assign bus.count    = r_count;
  assign bus.empty    = r_empty;
  assign bus.full     = r_full;
  assign bus.overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_seq_event_log.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_event_log
// Description : Self-checking bench for seq_event_log. A queue-based model of
//               the event log predicts every output after each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_event_log;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_event_log_if bus();

  seq_event_log #(.DEPTH(DEPTH), .TS_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_ts;
  int m_q[$];
  bit m_ovf;
  bit m_prev_step;
  int m_disp;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit rst_n, input bit sd, input bit mt, input bit st);
    int  cnt;
    bit  pop_req;
    bit  do_pop;
    int  new_disp;
    if (!rst_n) begin
      m_ts = 0; m_q.delete(); m_ovf = 0; m_prev_step = 0; m_disp = 0;
      return;
    end
    new_disp    = (m_q.size() != 0) ? m_q[0] : 0;
    pop_req     = st && !m_prev_step;
    m_prev_step = st;
    cnt         = m_q.size();
    do_pop      = pop_req && (cnt > 0);
    if (do_pop) void'(m_q.pop_front());
    if (sd) begin
      if (cnt < DEPTH || do_pop) m_q.push_back(m_ts);
      else m_ovf = 1;
    end
    if (mt) m_ts = 0;
    else if (m_ts < 65535) m_ts++;
    m_disp = new_disp;
  endtask

  function automatic int hex_val();
    return {16'd0, bus.hex3, bus.hex2, bus.hex1, bus.hex0};
  endfunction

  task automatic compare_all();
    check("count",    int'(bus.count), m_q.size());
    check("empty",    int'(bus.empty), int'(m_q.size() == 0));
    check("full",     int'(bus.full),  int'(m_q.size() == DEPTH));
    check("overflow", int'(bus.overflow), int'(m_ovf));
    check("hex",      hex_val(), m_disp);
  endtask

  // One clock: drive inputs, take the edge, update the model, sample at +1.
  task automatic cyc(input bit rst_n, input bit sd, input bit mt, input bit st,
                     input bit do_check = 1'b1);
    reset = rst_n; bus.seq_det = sd; bus.max_tick = mt; bus.step = st;
    @(posedge clk);
    model_edge(rst_n, sd, mt, st);
    #1;
    if (do_check) compare_all();
  endtask

  initial begin
    int saved;
    reset = 1'b0; bus.seq_det = 1'b0; bus.max_tick = 1'b0; bus.step = 1'b0;
    m_ts = 0; m_disp = 0; m_ovf = 0; m_prev_step = 0;

    // Reset state
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    check("rst_hex", hex_val(), 0);
    check("rst_empty", int'(bus.empty), 1);

    // max_tick then seq_det five edges later
    cyc(1, 0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    check("first_count", int'(bus.count), 1);
    cyc(1, 0, 0, 0);
    check("first_hex_latency", hex_val(), 4);

    // Fill past capacity: 7 more accepted, 2 dropped
    for (int i = 0; i < 9; i++) begin
      cyc(1, 1, 0, 0);
      cyc(1, 0, 0, 0);
    end
    check("fill_full", int'(bus.full), 1);
    check("fill_ovf", int'(bus.overflow), 1);
    check("fill_head", hex_val(), 4);

    // Hold step for 20 cycles: exactly one pop
    for (int i = 0; i < 20; i++) cyc(1, 0, 0, 1);
    check("hold_count", int'(bus.count), DEPTH - 1);
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 1);
    cyc(1, 0, 0, 0);
    check("repress_count", int'(bus.count), DEPTH - 2);

    // Refill to full, then push and step rise on the same edge
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    check("refull", int'(bus.full), 1);
    cyc(1, 1, 0, 1);
    check("full_pushpop_count", int'(bus.count), DEPTH);
    cyc(1, 0, 0, 0);

    // Drain to empty, then step rise and push together
    for (int i = 0; i < DEPTH + 2; i++) begin
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 0);
    end
    check("drained", int'(bus.empty), 1);
    saved = m_ts;
    cyc(1, 1, 0, 1);
    check("empty_pushpop_count", int'(bus.count), 1);
    cyc(1, 0, 0, 1);
    check("empty_pushpop_hex", hex_val(), saved);
    cyc(1, 0, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 199) != 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 3) == 0));
    end

    // Saturation: long run with no max_tick
    cyc(0, 0, 0, 0);
    cyc(1, 0, 1, 0);
    for (int i = 0; i < 70000; i++) cyc(1, 0, 0, 0, (i % 1000) == 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    check("saturated_hex", hex_val(), 32'h0000_FFFF);

    // Reset mid-operation
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
    check("final_rst_count", int'(bus.count), 0);
    check("final_rst_empty", int'(bus.empty), 1);
    check("final_rst_ovf", int'(bus.overflow), 0);
    check("final_rst_hex", hex_val(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
